// File: rtl/dot_product_accumulator_pkg.sv
// Shared types and width derivations for the product, popcount tree and accumulator stages.
package dot_product_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    VALID = 2'd2
  } acc_state_t;

  // Popcount width needed to represent 0..num_prods.
  function automatic int calc_tree_w(input int num_prods);
    return $clog2(num_prods + 1);
  endfunction

  // Largest dot product is every lane at (2**width-1)**2.
  function automatic int calc_acc_w(input int num_prods, input int width);
    return $clog2(num_prods * (2 ** width - 1) ** 2 + 1);
  endfunction

endpackage

// File: rtl/dot_product_accumulator_sat_adder.sv
// Unsigned saturating adder: a + zero-extended b, clamped to all-ones on carry-out.
module sat_adder #(
  parameter int ACC_W  = 12,
  parameter int TREE_W = 5
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [TREE_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              sat
);

  localparam int PAD_W = ACC_W + 1 - TREE_W;

  logic [ACC_W:0] wide;

  assign wide = {1'b0, a} + {{PAD_W{1'b0}}, b};
  assign sat  = wide[ACC_W];
  assign sum  = sat ? {ACC_W{1'b1}} : wide[ACC_W-1:0];

endmodule

// File: rtl/dot_product_accumulator.sv
// Accumulates per-cycle popcounts into a dot product, then offers it with a threshold spike
// over valid/ready; a watchdog aborts runs whose lanes never all report done.
module dot_product_accumulator
  import dot_product_accumulator_pkg::*;
#(
  parameter int NUM_PRODS = 16,
  parameter int WIDTH     = 4,
  parameter int TREE_W    = calc_tree_w(NUM_PRODS),
  parameter int ACC_W     = calc_acc_w(NUM_PRODS, WIDTH),
  parameter int TIMEOUT   = (2 ** WIDTH) ** 2 + 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [TREE_W-1:0]    sum_in,
  input  logic [NUM_PRODS-1:0] pb_done,
  input  logic [ACC_W-1:0]     threshold,
  output logic [ACC_W-1:0]     acc_out,
  output logic                 spike,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic                 busy,
  output logic                 overflow,
  output logic                 timeout_err,
  output logic                 dropped
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] thr_q, thr_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic             spike_q, spike_d;
  logic             overflow_q, overflow_d;
  logic             timeout_err_q, timeout_err_d;
  logic             dropped_q, dropped_d;

  logic [ACC_W-1:0] acc_sum;
  logic             acc_sat;
  logic             lanes_done;
  logic             watchdog;

  sat_adder #(
    .ACC_W (ACC_W),
    .TREE_W(TREE_W)
  ) u_sat_adder (
    .a  (acc_q),
    .b  (sum_in),
    .sum(acc_sum),
    .sat(acc_sat)
  );

  // Done flags seen in the first ACCUM cycle may be stale from the previous run.
  assign lanes_done = (&pb_done) && (cnt_q != '0);
  assign watchdog   = (cnt_q == CNT_W'(TIMEOUT - 1));

  // NOTE: every _d gets its hold value first, so no path through the case leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    thr_d         = thr_q;
    acc_out_d     = acc_out_q;
    spike_d       = spike_q;
    overflow_d    = overflow_q;
    timeout_err_d = timeout_err_q;
    dropped_d     = 1'b0;

    if (start) begin
      state_d       = ACCUM;
      acc_d         = '0;
      cnt_d         = '0;
      thr_d         = threshold;
      overflow_d    = 1'b0;
      timeout_err_d = 1'b0;
      dropped_d     = (state_q == VALID) && !acc_ready;
    end else begin
      case (state_q)
        ACCUM: begin
          acc_d = acc_sum;
          cnt_d = cnt_q + 1'b1;
          if (acc_sat) overflow_d = 1'b1;
          if (lanes_done || watchdog) begin
            state_d   = VALID;
            acc_out_d = acc_sum;
            spike_d   = (acc_sum >= thr_q);
            if (!lanes_done) timeout_err_d = 1'b1;
          end
        end
        VALID: begin
          if (acc_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      thr_q         <= '0;
      acc_out_q     <= '0;
      spike_q       <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      thr_q         <= thr_d;
      acc_out_q     <= acc_out_d;
      spike_q       <= spike_d;
      overflow_q    <= overflow_d;
      timeout_err_q <= timeout_err_d;
      dropped_q     <= dropped_d;
    end
  end

  assign acc_out     = acc_out_q;
  assign spike       = spike_q;
  assign acc_valid   = (state_q == VALID);
  assign busy        = (state_q == ACCUM);
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Directed bench: a behavioural model of identical product lanes drives the accumulator.
module tb_dot_product_accumulator;

  localparam int NP = 16;
  localparam int TW = 5;
  localparam int AW = 12;
  localparam int TO = 260;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [TW-1:0] sum_in;
  logic [NP-1:0] pb_done;
  logic [AW-1:0] threshold;
  logic [AW-1:0] acc_out;
  logic          spike, acc_valid, acc_ready, busy, overflow, timeout_err, dropped;

  logic [9:0]    thr10, acc_out10;
  logic          spike10, valid10, busy10, ovf10, to10, drop10;

  int n_cmp = 0;
  int n_err = 0;
  int drop_cnt = 0;

  dot_product_accumulator dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sum_in(sum_in), .pb_done(pb_done),
    .threshold(threshold), .acc_out(acc_out), .spike(spike), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .busy(busy), .overflow(overflow), .timeout_err(timeout_err),
    .dropped(dropped)
  );

  dot_product_accumulator #(.ACC_W(10)) dut10 (
    .clk(clk), .reset_n(reset_n), .start(start), .sum_in(sum_in), .pb_done(pb_done),
    .threshold(thr10), .acc_out(acc_out10), .spike(spike10), .acc_valid(valid10),
    .acc_ready(acc_ready), .busy(busy10), .overflow(ovf10), .timeout_err(to10),
    .dropped(drop10)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dropped) drop_cnt++;

  task automatic do_start(input logic [AW-1:0] thr);
    start = 1'b1;
    threshold = thr;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Every lane emits p unary ones then holds done; lane `stuck` never reports done.
  task automatic run_lanes(input int p, input int stuck, output int cycles);
    cycles = 0;
    while (busy && cycles < 400) begin
      sum_in = (cycles < p) ? TW'(NP) : '0;
      if (cycles == 0) pb_done = '1;
      else pb_done = (cycles >= p) ? '1 : '0;
      if (stuck >= 0) pb_done[stuck] = 1'b0;
      @(posedge clk); #1;
      cycles++;
    end
    sum_in = '0;
    n_cmp++;
    if (busy) begin
      n_err++;
      $display("FAIL run_bound: still busy after %0d cycles, required done", cycles);
    end
  endtask

  task automatic handshake();
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    n_cmp++;
    if (acc_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL handshake_idle: acc_valid=%b busy=%b, required 0 0", acc_valid, busy);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({busy, acc_valid, spike, overflow, timeout_err, dropped} !== 6'b0 || acc_out !== '0) begin
      n_err++;
      $display("FAIL reset_state: flags=%b acc_out=%0d, required all 0",
               {busy, acc_valid, spike, overflow, timeout_err, dropped}, acc_out);
    end
  endtask

  task automatic test_basic();
    int cyc;
    do_start(12'd10);
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: busy=%b, required 1", busy); end
    run_lanes(1, -1, cyc);
    n_cmp++;
    if (cyc != 2) begin n_err++; $display("FAIL basic_latency: %0d cycles, required 2", cyc); end
    n_cmp++;
    if (acc_valid !== 1'b1 || acc_out !== 12'd16 || spike !== 1'b1 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: valid=%b acc_out=%0d spike=%b ovf=%b, required 1 16 1 0",
               acc_valid, acc_out, spike, overflow);
    end
    handshake();
  endtask

  task automatic test_stall();
    int cyc;
    do_start(12'd200);
    run_lanes(6, -1, cyc);
    n_cmp++;
    if (acc_out !== 12'd96 || spike !== 1'b0 || cyc != 7) begin
      n_err++;
      $display("FAIL stall_result: acc_out=%0d spike=%b cycles=%0d, required 96 0 7", acc_out, spike, cyc);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (acc_valid !== 1'b1 || acc_out !== 12'd96 || spike !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold%0d: valid=%b acc_out=%0d spike=%b, required 1 96 0",
                 i, acc_valid, acc_out, spike);
      end
    end
    handshake();
  endtask

  task automatic test_overflow();
    int cyc;
    thr10 = 10'd1000;
    do_start(12'd4000);
    run_lanes(225, -1, cyc);
    n_cmp++;
    if (acc_out !== 12'd3600 || overflow !== 1'b0 || spike !== 1'b0 || cyc != 226) begin
      n_err++;
      $display("FAIL full_scale: acc_out=%0d ovf=%b spike=%b cycles=%0d, required 3600 0 0 226",
               acc_out, overflow, spike, cyc);
    end
    n_cmp++;
    if (acc_out10 !== 10'd1023 || ovf10 !== 1'b1 || spike10 !== 1'b1 || valid10 !== 1'b1) begin
      n_err++;
      $display("FAIL saturate10: acc_out=%0d ovf=%b spike=%b valid=%b, required 1023 1 1 1",
               acc_out10, ovf10, spike10, valid10);
    end
    handshake();
  endtask

  task automatic test_timeout();
    int cyc;
    drop_cnt = 0;
    do_start(12'd16);
    run_lanes(1, 7, cyc);
    n_cmp++;
    if (cyc != TO || timeout_err !== 1'b1 || acc_valid !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_hit: cycles=%0d terr=%b valid=%b, required %0d 1 1",
               cyc, timeout_err, acc_valid, TO);
    end
    n_cmp++;
    if (acc_out !== 12'd16 || spike !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_value: acc_out=%0d spike=%b, required 16 1", acc_out, spike);
    end
    // Start coincident with acceptance: result taken, new run begins, nothing dropped.
    start = 1'b1; acc_ready = 1'b1; threshold = 12'd10;
    @(posedge clk); #1;
    start = 1'b0; acc_ready = 1'b0;
    n_cmp++;
    if (timeout_err !== 1'b0 || busy !== 1'b1 || dropped !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_clear: terr=%b busy=%b dropped=%b, required 0 1 0",
               timeout_err, busy, dropped);
    end
    run_lanes(1, -1, cyc);
    n_cmp++;
    if (acc_out !== 12'd16 || timeout_err !== 1'b0 || drop_cnt != 0) begin
      n_err++;
      $display("FAIL timeout_rerun: acc_out=%0d terr=%b drops=%0d, required 16 0 0",
               acc_out, timeout_err, drop_cnt);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int cyc;
    drop_cnt = 0;
    do_start(12'd500);
    for (int i = 0; i < 5; i++) begin
      sum_in = TW'(NP);
      pb_done = '0;
      @(posedge clk); #1;
    end
    start = 1'b1; threshold = 12'd16;
    @(posedge clk); #1;
    start = 1'b0;
    run_lanes(1, -1, cyc);
    n_cmp++;
    if (acc_out !== 12'd16 || spike !== 1'b1 || drop_cnt != 0) begin
      n_err++;
      $display("FAIL restart_result: acc_out=%0d spike=%b drops=%0d, required 16 1 0",
               acc_out, spike, drop_cnt);
    end
    start = 1'b1; threshold = 12'd32;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (dropped !== 1'b1 || busy !== 1'b1 || acc_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_pulse: dropped=%b busy=%b valid=%b, required 1 1 0", dropped, busy, acc_valid);
    end
    run_lanes(2, -1, cyc);
    n_cmp++;
    if (acc_out !== 12'd32 || spike !== 1'b1 || drop_cnt != 1) begin
      n_err++;
      $display("FAIL drop_result: acc_out=%0d spike=%b drops=%0d, required 32 1 1",
               acc_out, spike, drop_cnt);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_start(12'd10);
    for (int i = 0; i < 3; i++) begin
      sum_in = TW'(NP);
      pb_done = '0;
      @(posedge clk); #1;
    end
    #3 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, acc_valid, spike, overflow, timeout_err, dropped} !== 6'b0 || acc_out !== '0) begin
      n_err++;
      $display("FAIL async_reset: flags=%b acc_out=%0d, required all 0",
               {busy, acc_valid, spike, overflow, timeout_err, dropped}, acc_out);
    end
    sum_in = '0;
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    do_start(12'd10);
    run_lanes(1, -1, cyc);
    n_cmp++;
    if (acc_out !== 12'd16 || spike !== 1'b1 || acc_valid !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset: acc_out=%0d spike=%b valid=%b, required 16 1 1", acc_out, spike, acc_valid);
    end
    handshake();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; sum_in = '0; pb_done = '0;
    threshold = '0; thr10 = '0; acc_ready = 1'b0;
    #12;
    test_reset();
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_stall();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
